// File: rtl/bus_term_fifo_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bus_term_fifo_bank : per-terminal TX/RX FWFT queues with error policing.   |
// | Optional statistics counters enabled by the macro BUS_FIFO_STATS_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module bus_term_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       rd_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       wr_acc_o,
  output logic                       rd_acc_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          empty, full, wr_acc, rd_acc;

  assign empty  = (level_q == '0);
  assign full   = (level_q == LW'(DEPTH));
  assign rd_acc = rd_i & ~empty;
  // A read on a full queue frees the slot the same-edge write lands in.
  assign wr_acc = wr_i & (~full | rd_acc);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (wr_acc) wptr_d = wptr_q + PW'(1);
    if (rd_acc) rptr_d = rptr_q + PW'(1);
    if (wr_acc && !rd_acc)      level_d = level_q + LW'(1);
    else if (rd_acc && !wr_acc) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o  = mem_q[rptr_q];
  assign level_o  = level_q;
  assign wr_acc_o = wr_acc;
  assign rd_acc_o = rd_acc;
endmodule

module bus_term_fifo_bank #(
  parameter int           pckg_sz   = 16,
  parameter int           drvrs     = 4,
  parameter int           deep_fifo = 8,
  parameter logic [7:0]   broadcast = 8'hFF
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [drvrs-1:0]                       wr_en,
  input  logic [drvrs*pckg_sz-1:0]               wr_data,
  output logic [drvrs-1:0]                       wr_full,
  output logic [drvrs-1:0]                       pndng,
  output logic [drvrs*pckg_sz-1:0]               D_pop,
  input  logic [drvrs-1:0]                       pop,
  input  logic [drvrs-1:0]                       push,
  input  logic [drvrs*pckg_sz-1:0]               D_push,
  input  logic [drvrs-1:0]                       rd_en,
  output logic [drvrs-1:0]                       rx_valid,
  output logic [drvrs*pckg_sz-1:0]               rx_data,
  output logic [drvrs*($clog2(deep_fifo)+1)-1:0] tx_level,
  output logic [drvrs*($clog2(deep_fifo)+1)-1:0] rx_level,
  output logic [drvrs-1:0]                       err_ovf,
  output logic [drvrs-1:0]                       err_unf,
  output logic [drvrs-1:0]                       err_misroute,
  output logic [drvrs*16-1:0]                    tx_cnt,
  output logic [drvrs*16-1:0]                    rx_cnt
);
  localparam int LW = $clog2(deep_fifo) + 1;

  for (genvar i = 0; i < drvrs; i++) begin : g_term
    logic [LW-1:0] tx_lvl, rx_lvl;
    logic          tx_wr_acc, tx_rd_acc, rx_wr_acc, rx_rd_acc;
    logic [7:0]    rx_id;
    logic          ovf_q, unf_q, mis_q;

    bus_term_fifo #(.W(pckg_sz), .DEPTH(deep_fifo)) u_tx (
      .clk      (clk),
      .reset    (reset),
      .wr_i     (wr_en[i]),
      .wdata_i  (wr_data[i*pckg_sz +: pckg_sz]),
      .rd_i     (pop[i]),
      .rdata_o  (D_pop[i*pckg_sz +: pckg_sz]),
      .level_o  (tx_lvl),
      .wr_acc_o (tx_wr_acc),
      .rd_acc_o (tx_rd_acc)
    );

    bus_term_fifo #(.W(pckg_sz), .DEPTH(deep_fifo)) u_rx (
      .clk      (clk),
      .reset    (reset),
      .wr_i     (push[i]),
      .wdata_i  (D_push[i*pckg_sz +: pckg_sz]),
      .rd_i     (rd_en[i]),
      .rdata_o  (rx_data[i*pckg_sz +: pckg_sz]),
      .level_o  (rx_lvl),
      .wr_acc_o (rx_wr_acc),
      .rd_acc_o (rx_rd_acc)
    );

    assign rx_id = D_push[i*pckg_sz + pckg_sz - 8 +: 8];

    always_ff @(posedge clk) begin
      if (reset) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
        mis_q <= 1'b0;
      end else begin
        if ((wr_en[i] && !tx_wr_acc) || (push[i] && !rx_wr_acc)) ovf_q <= 1'b1;
        if ((pop[i] && !tx_rd_acc) || (rd_en[i] && !rx_rd_acc))  unf_q <= 1'b1;
        if (rx_wr_acc && rx_id != 8'(i) && rx_id != broadcast)    mis_q <= 1'b1;
      end
    end

    assign tx_level[i*LW +: LW] = tx_lvl;
    assign rx_level[i*LW +: LW] = rx_lvl;
    assign wr_full[i]      = (tx_lvl == LW'(deep_fifo));
    assign pndng[i]        = (tx_lvl != '0);
    assign rx_valid[i]     = (rx_lvl != '0);
    assign err_ovf[i]      = ovf_q;
    assign err_unf[i]      = unf_q;
    assign err_misroute[i] = mis_q;

`ifdef BUS_FIFO_STATS_EN
    logic [15:0] tx_cnt_q, rx_cnt_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        tx_cnt_q <= '0;
        rx_cnt_q <= '0;
      end else begin
        if (tx_rd_acc && tx_cnt_q != 16'hFFFF) tx_cnt_q <= tx_cnt_q + 16'd1;
        if (rx_wr_acc && rx_cnt_q != 16'hFFFF) rx_cnt_q <= rx_cnt_q + 16'd1;
      end
    end

    assign tx_cnt[i*16 +: 16] = tx_cnt_q;
    assign rx_cnt[i*16 +: 16] = rx_cnt_q;
`else
    assign tx_cnt[i*16 +: 16] = '0;
    assign rx_cnt[i*16 +: 16] = '0;
`endif
  end
endmodule
`default_nettype wire

// File: tb/tb_bus_term_fifo_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bus_term_fifo_bank : directed vector bench for bus_term_fifo_bank.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bus_term_fifo_bank;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  wr_en, pop, push, rd_en;
  logic [63:0] wr_data, D_push;
  logic [3:0]  wr_full, pndng, rx_valid, err_ovf, err_unf, err_misroute;
  logic [63:0] D_pop, rx_data, tx_cnt, rx_cnt;
  logic [15:0] tx_level, rx_level;

  int n_vec = 0;
  int n_err = 0;

  bus_term_fifo_bank dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push), .D_push(D_push),
    .rd_en(rd_en), .rx_valid(rx_valid), .rx_data(rx_data), .tx_level(tx_level),
    .rx_level(rx_level), .err_ovf(err_ovf), .err_unf(err_unf),
    .err_misroute(err_misroute), .tx_cnt(tx_cnt), .rx_cnt(rx_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  wr_en;
    logic [63:0] wr_data;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [63:0] d_push;
    logic [3:0]  rd_en;
    logic [3:0]  e_pndng, e_full, e_rxv;
    logic [15:0] e_txl, e_rxl;
    logic [3:0]  e_ovf, e_unf, e_mis;
    logic [63:0] e_dpop, e_rxd;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] mask4(input logic [3:0] v);
    logic [63:0] m;
    for (int j = 0; j < 4; j++) m[j*16 +: 16] = {16{v[j]}};
    return m;
  endfunction

  task automatic clear_in();
    reset = 1'b0; wr_en = '0; pop = '0; push = '0; rd_en = '0;
    wr_data = '0; D_push = '0;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] m;
    int rd_n;
    clear_in();
    reset = 1'b1;

    // Basic TX, misroute/broadcast, underflow, empty write+read, reset mid-fill.
    tbl[0]  = '{1, 4'h0, 64'h0, 4'h0, 4'h0, 64'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0};
    tbl[1]  = '{0, 4'h2, 64'h0000_0000_0202_0000, 4'h0, 4'h0, 64'h0, 4'h0, 4'h2, 4'h0, 4'h0, 16'h0010, 16'h0, 4'h0, 4'h0, 4'h0, 64'h0000_0000_0202_0000, 64'h0};
    tbl[2]  = '{0, 4'h0, 64'h0, 4'h2, 4'h0, 64'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0};
    tbl[3]  = '{0, 4'h0, 64'h0, 4'h0, 4'h4, 64'h0000_0155_0000_0000, 4'h0, 4'h0, 4'h0, 4'h4, 16'h0, 16'h0100, 4'h0, 4'h0, 4'h4, 64'h0, 64'h0000_0155_0000_0000};
    tbl[4]  = '{0, 4'h0, 64'h0, 4'h0, 4'h1, 64'h0000_0000_0000_FF11, 4'h0, 4'h0, 4'h0, 4'h5, 16'h0, 16'h0101, 4'h0, 4'h0, 4'h4, 64'h0, 64'h0000_0155_0000_FF11};
    tbl[5]  = '{0, 4'h0, 64'h0, 4'h0, 4'h0, 64'h0, 4'h5, 4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 4'h0, 4'h0, 4'h4, 64'h0, 64'h0};
    tbl[6]  = '{0, 4'h0, 64'h0, 4'h0, 4'h0, 64'h0, 4'h8, 4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 4'h0, 4'h8, 4'h4, 64'h0, 64'h0};
    tbl[7]  = '{0, 4'h0, 64'h0, 4'h0, 4'h2, 64'h0000_0000_0177_0000, 4'h2, 4'h0, 4'h0, 4'h2, 16'h0, 16'h0010, 4'h0, 4'hA, 4'h4, 64'h0, 64'h0000_0000_0177_0000};
    for (int k = 0; k < 5; k++) begin
      tbl[8+k] = '{0, 4'h4, 64'h0, 4'h0, 4'h0, 64'h0, 4'h0, 4'h4, 4'h0, 4'h2, 16'h0, 16'h0010, 4'h0, 4'hA, 4'h4, 64'h0000_02A0_0000_0000, 64'h0000_0000_0177_0000};
      tbl[8+k].wr_data[47:32] = 16'h02A0 + 16'(k);
      tbl[8+k].e_txl[11:8]    = 4'(k + 1);
    end
    tbl[13] = '{1, 4'h0, 64'h0, 4'h0, 4'h0, 64'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0};

    @(negedge clk);
    for (int k = 0; k < 14; k++) begin
      reset = tbl[k].rst; wr_en = tbl[k].wr_en; wr_data = tbl[k].wr_data;
      pop = tbl[k].pop; push = tbl[k].push; D_push = tbl[k].d_push; rd_en = tbl[k].rd_en;
      @(negedge clk);
      chk($sformatf("v%0d pndng", k),    64'(pndng),        64'(tbl[k].e_pndng));
      chk($sformatf("v%0d wr_full", k),  64'(wr_full),      64'(tbl[k].e_full));
      chk($sformatf("v%0d rx_valid", k), 64'(rx_valid),     64'(tbl[k].e_rxv));
      chk($sformatf("v%0d tx_level", k), 64'(tx_level),     64'(tbl[k].e_txl));
      chk($sformatf("v%0d rx_level", k), 64'(rx_level),     64'(tbl[k].e_rxl));
      chk($sformatf("v%0d err_ovf", k),  64'(err_ovf),      64'(tbl[k].e_ovf));
      chk($sformatf("v%0d err_unf", k),  64'(err_unf),      64'(tbl[k].e_unf));
      chk($sformatf("v%0d err_mis", k),  64'(err_misroute), 64'(tbl[k].e_mis));
      m = mask4(tbl[k].e_pndng);
      chk($sformatf("v%0d D_pop", k),    D_pop & m,         tbl[k].e_dpop & m);
      m = mask4(tbl[k].e_rxv);
      chk($sformatf("v%0d rx_data", k),  rx_data & m,       tbl[k].e_rxd & m);
    end
    clear_in();

    // TX[0] fill, overflow drop, write+pop on full, ordered drain.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      wr_en[0] = 1'b1; wr_data[15:0] = 16'h1000 + 16'(k);
      @(negedge clk);
    end
    clear_in();
    chk("full wr_full", 64'(wr_full), 64'h1);
    chk("full level",   64'(tx_level[3:0]), 64'd8);
    chk("full no ovf",  64'(err_ovf), 64'h0);
    wr_en[0] = 1'b1; wr_data[15:0] = 16'hAAAA;
    @(negedge clk);
    clear_in();
    chk("ovf flag",  64'(err_ovf), 64'h1);
    chk("ovf level", 64'(tx_level[3:0]), 64'd8);
    chk("ovf head",  64'(D_pop[15:0]), 64'h1000);
    wr_en[0] = 1'b1; wr_data[15:0] = 16'h1008; pop[0] = 1'b1;
    @(negedge clk);
    clear_in();
    chk("wrpop level", 64'(tx_level[3:0]), 64'd8);
    chk("wrpop head",  64'(D_pop[15:0]), 64'h1001);
    chk("wrpop unf",   64'(err_unf), 64'h0);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain%0d pndng", k), 64'(pndng[0]), 64'h1);
      chk($sformatf("drain%0d head", k),  64'(D_pop[15:0]), 64'(16'h1000 + 16'(k)));
      pop[0] = 1'b1;
      @(negedge clk);
      pop[0] = 1'b0;
    end
    chk("drained pndng", 64'(pndng), 64'h0);
    chk("drained level", 64'(tx_level), 64'h0);

    // RX[3] wrap-around: 12 pushes, draining one per cycle from the fifth.
    do_reset();
    rd_n = 0;
    for (int k = 0; k < 16; k++) begin
      if (k < 12) begin
        push[3] = 1'b1; D_push[63:48] = 16'h0300 + 16'(k);
      end
      if (k >= 4) begin
        chk($sformatf("wrap%0d valid", k), 64'(rx_valid[3]), 64'h1);
        chk($sformatf("wrap%0d data", k),  64'(rx_data[63:48]), 64'(16'h0300 + 16'(rd_n)));
        rd_en[3] = 1'b1;
        rd_n++;
      end
      @(negedge clk);
      clear_in();
    end
    chk("wrap level", 64'(rx_level), 64'h0);
    chk("wrap valid", 64'(rx_valid), 64'h0);
    chk("wrap errs",  64'({err_ovf, err_unf, err_misroute}), 64'h0);

    // Statistics: 3 pops from TX[1], 2 pushes into RX[1], one empty pop.
    do_reset();
    chk("cnt reset tx", tx_cnt, 64'h0);
    chk("cnt reset rx", rx_cnt, 64'h0);
    for (int k = 0; k < 3; k++) begin
      wr_en[1] = 1'b1; wr_data[31:16] = 16'h0101 + 16'(k);
      @(negedge clk);
    end
    clear_in();
    for (int k = 0; k < 4; k++) begin
      pop[1] = 1'b1;
      if (k < 2) begin
        push[1] = 1'b1; D_push[31:16] = 16'h01C0 + 16'(k);
      end
      @(negedge clk);
      clear_in();
    end
    chk("stats unf", 64'(err_unf), 64'h2);
    chk("stats mis", 64'(err_misroute), 64'h0);
`ifdef BUS_FIFO_STATS_EN
    chk("stats tx_cnt", tx_cnt, 64'h0000_0000_0003_0000);
    chk("stats rx_cnt", rx_cnt, 64'h0000_0000_0002_0000);
`else
    chk("stats tx_cnt", tx_cnt, 64'h0);
    chk("stats rx_cnt", rx_cnt, 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
